hp48_bus_ram: RTL and testbench
===============================

// Module: hp48_bus_ram
// PURPOSE
//  Responder end of the HP48 nibble bus: a configurable nibble RAM that executes the core's bus commands.
//  Tracks its own PC and DP pointers, answers PC/DP reads, accepts DP writes.
//  Claims an address window through the two-step CONFIGURE sequence. Instanced inside hp48_bus beside the ROM.
// PARAMETERS
//  ADDR_BITS   12     log2 of RAM depth in nibbles (4096 nibbles)
//  INIT_FILE   ""     optional $readmemh image; empty means RAM is not preloaded
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-low
//  strobe      in   1   one-cycle qualifier: command/address/nibble_in valid this cycle
//  command     in   4   bus command code
//  address     in   20  address for LOAD_PC, LOAD_DP and CONFIGURE
//  nibble_in   in   4   write data for DP_WRITE
//  nibble_out  out  4   read data, registered
//  selected    out  1   high while nibble_out holds data from a read that hit this module
//  configured  out  1   window base is valid
//  bus_error   out  1   sticky illegal-command flag
// BEHAVIOUR
//  Command codes: NOP=0, PC_READ=1, DP_READ=2, DP_WRITE=3, LOAD_PC=4, LOAD_DP=5, CONFIGURE=6, RESET=7.
//   Codes 8-F are illegal.
//  Reset (reset==0 at posedge): pc_ptr=0, dp_ptr=0, mask=0, base=0, state=UNCONF.
//   nibble_out=0, selected=0, configured=0, bus_error=0. RAM contents are kept.
//   Reset has priority over a simultaneous strobe.
//  No strobe: all state holds, except selected, which clears one cycle after a read.
//  Config FSM:
//   UNCONF --CONFIGURE--> SIZED: mask <= address.
//   SIZED --CONFIGURE--> CONF: base <= address & mask; configured=1.
//   CONF ignores further CONFIGURE.
//   RESET cmd: any state -> UNCONF; mask and base cleared; pointers and RAM kept.
//  hit(a) = configured && ((a & mask) == base). RAM index = a[ADDR_BITS-1:0].
//   A window larger than the RAM aliases.
//  LOAD_PC / LOAD_DP: pc_ptr / dp_ptr <= address. Applies whether or not the address hits.
//  PC_READ:
//   Hit: nibble_out <= ram[pc_ptr] and selected <= 1, both visible the cycle after the strobe (latency 1).
//   Miss: nibble_out <= 0, selected <= 0.
//   pc_ptr <= pc_ptr+1 in either case.
//  DP_READ: same as PC_READ, using dp_ptr.
//  DP_WRITE: on hit, ram[dp_ptr] <= nibble_in. dp_ptr <= dp_ptr+1 in either case. nibble_out unchanged; selected <= 0.
//  Pointers are 20-bit and wrap FFFFF -> 00000.
//  Illegal code with strobe: bus_error <= 1, no other effect. Cleared only by reset or the RESET command.
//  NOP with strobe: no effect. Exactly one command executes per strobe; there is no queuing.
// CONFIGURATION
//  HP48_BUS_RAM_DAISY_EN defined:
//   Adds ports daisy_in (in, 1) and daisy_out (out, 1); daisy_out = configured.
//   CONFIGURE is accepted only while daisy_in==1, and is ignored otherwise.
//  Not defined: no daisy ports; CONFIGURE is always accepted.
// STRUCTURE
//  Shared header hp48_bus_defs.vh: BUSCMD_* codes, CFG_UNCONF/CFG_SIZED/CFG_CONF state encodings.
//  Sub-module hp48_bus_ram_array: 2^ADDR_BITS x 4 nibble RAM.
//   One synchronous write port and one registered read port; infers block RAM.
//  Top level: command decode, config FSM, pointer registers, error flag.
// TESTING
//  1. Release reset, strobe NOP -> all outputs 0. PC_READ -> selected=0, nibble_out=0, bus_error=0.
//  2. CONFIGURE F0000, then CONFIGURE 80000 -> configured=1 after the second strobe.
//     Then LOAD_DP 80010, DP_WRITE A, DP_WRITE 5, LOAD_PC 80010, PC_READ x2 -> nibble_out A then 5, selected=1.
//  3. Configured as in 2: LOAD_DP 90000, DP_WRITE 7 -> no RAM change.
//     LOAD_PC 90000, PC_READ -> selected=0; LOAD_PC 80000, PC_READ -> prior content.
//  4. LOAD_PC FFFFF, two PC_READs -> pc_ptr wraps; second read returns ram[0] when the window is based at 00000.
//  5. Strobe command 9 -> bus_error=1 held. RESET cmd -> bus_error=0, configured=0, earlier RAM data still readable after reconfigure.
//  6. Reset asserted between the two CONFIGUREs -> state UNCONF.
//     DAISY_EN build: CONFIGURE with daisy_in=0 ignored; with daisy_in=1 daisy_out rises after the second CONFIGURE.

Source files
------------

// File: rtl/hp48_bus_ram_pkg.sv
// Shared definitions for the HP48 nibble-bus RAM responder: bus command
// codes, configuration FSM states and the window hit helper.
package hp48_bus_ram_pkg;

  localparam int unsigned BusAddrW = 20;

  localparam logic [3:0] BusCmdNop       = 4'h0;
  localparam logic [3:0] BusCmdPcRead    = 4'h1;
  localparam logic [3:0] BusCmdDpRead    = 4'h2;
  localparam logic [3:0] BusCmdDpWrite   = 4'h3;
  localparam logic [3:0] BusCmdLoadPc    = 4'h4;
  localparam logic [3:0] BusCmdLoadDp    = 4'h5;
  localparam logic [3:0] BusCmdConfigure = 4'h6;
  localparam logic [3:0] BusCmdReset     = 4'h7;

  typedef enum logic [1:0] {
    CfgUnconf = 2'd0,
    CfgSized  = 2'd1,
    CfgConf   = 2'd2
  } cfg_state_e;

  // An address hits when the window is claimed and its masked bits match the base.
  function automatic logic addr_hit(input logic [BusAddrW-1:0] addr,
                                    input logic [BusAddrW-1:0] mask,
                                    input logic [BusAddrW-1:0] base,
                                    input logic                configured);
    return configured && ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/hp48_bus_ram_array.sv
// Nibble RAM of 2^ADDR_BITS x 4: one synchronous write port and one
// registered read port. The read register only updates on rd_en_i so the
// last read value is held between reads. Contents are not reset.
module hp48_bus_ram_array #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [3:0]           wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [3:0]           rd_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [3:0] mem [Depth];
  logic [3:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hp48_bus_ram.sv
// HP48 nibble-bus RAM responder: command decode, two-step CONFIGURE FSM,
// PC/DP pointer registers and the sticky bus error flag.
// Optional build macro HP48_BUS_RAM_DAISY_EN adds daisy_in/daisy_out; with it,
// CONFIGURE is only accepted while daisy_in is high and daisy_out mirrors configured.
module hp48_bus_ram
  import hp48_bus_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe,
  input  logic [3:0]    command,
  input  logic [19:0]   address,
  input  logic [3:0]    nibble_in,
  output logic [3:0]    nibble_out,
  output logic          selected,
  output logic          configured,
`ifdef HP48_BUS_RAM_DAISY_EN
  input  logic          daisy_in,
  output logic          daisy_out,
`endif
  output logic          bus_error
);

  logic [19:0] pc_q, pc_d;
  logic [19:0] dp_q, dp_d;
  logic [19:0] mask_q, mask_d;
  logic [19:0] base_q, base_d;
  cfg_state_e  cfg_q, cfg_d;
  logic        out_valid_q, out_valid_d;  // nibble_out shows RAM read data, else 0
  logic        sel_q, sel_d;
  logic        err_q, err_d;

  logic                 cfg_accept;
  logic                 is_conf;
  logic                 pc_hit;
  logic                 dp_hit;
  logic                 ram_we;
  logic                 ram_re;
  logic [ADDR_BITS-1:0] ram_rd_addr;
  logic [3:0]           ram_rd_data;

`ifdef HP48_BUS_RAM_DAISY_EN
  assign cfg_accept = daisy_in;
  assign daisy_out  = is_conf;
`else
  assign cfg_accept = 1'b1;
`endif

  assign is_conf = (cfg_q == CfgConf);
  assign pc_hit  = addr_hit(pc_q, mask_q, base_q, is_conf);
  assign dp_hit  = addr_hit(dp_q, mask_q, base_q, is_conf);

  // Next-state decode for one strobed command; selected drops unless a read hits.
  always_comb begin
    pc_d        = pc_q;
    dp_d        = dp_q;
    mask_d      = mask_q;
    base_d      = base_q;
    cfg_d       = cfg_q;
    out_valid_d = out_valid_q;
    sel_d       = 1'b0;
    err_d       = err_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_rd_addr = pc_q[ADDR_BITS-1:0];
    if (strobe) begin
      case (command)
        BusCmdNop: ;
        BusCmdPcRead: begin
          ram_re      = pc_hit;
          out_valid_d = pc_hit;
          sel_d       = pc_hit;
          pc_d        = pc_q + 20'd1;
        end
        BusCmdDpRead: begin
          ram_rd_addr = dp_q[ADDR_BITS-1:0];
          ram_re      = dp_hit;
          out_valid_d = dp_hit;
          sel_d       = dp_hit;
          dp_d        = dp_q + 20'd1;
        end
        BusCmdDpWrite: begin
          ram_we = dp_hit;
          dp_d   = dp_q + 20'd1;
        end
        BusCmdLoadPc: pc_d = address;
        BusCmdLoadDp: dp_d = address;
        BusCmdConfigure: begin
          if (cfg_accept) begin
            if (cfg_q == CfgUnconf) begin
              mask_d = address;
              cfg_d  = CfgSized;
            end else if (cfg_q == CfgSized) begin
              base_d = address & mask_q;
              cfg_d  = CfgConf;
            end
          end
        end
        BusCmdReset: begin
          cfg_d  = CfgUnconf;
          mask_d = '0;
          base_d = '0;
          err_d  = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State registers with synchronous active-low reset taking priority over strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= '0;
      dp_q        <= '0;
      mask_q      <= '0;
      base_q      <= '0;
      cfg_q       <= CfgUnconf;
      out_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      dp_q        <= dp_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      cfg_q       <= cfg_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
    end
  end

  hp48_bus_ram_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (ram_we & reset),
    .wr_addr_i (dp_q[ADDR_BITS-1:0]),
    .wr_data_i (nibble_in),
    .rd_en_i   (ram_re & reset),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  assign nibble_out = out_valid_q ? ram_rd_data : 4'h0;
  assign selected   = sel_q;
  assign configured = is_conf;
  assign bus_error  = err_q;

endmodule

// File: tb/tb_hp48_bus_ram.sv
// Self-checking bench for hp48_bus_ram: directed scenarios plus randomized
// command streams compared against a behavioural model of the bus RAM.
module tb_hp48_bus_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [3:0]  command;
  logic [19:0] address;
  logic [3:0]  nibble_in;
  logic [3:0]  nibble_out;
  logic        selected;
  logic        configured;
  logic        bus_error;
  logic        daisy_in;
`ifdef HP48_BUS_RAM_DAISY_EN
  logic        daisy_out;
`endif

  always #5 clk = ~clk;

  hp48_bus_ram #(
    .ADDR_BITS (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe),
    .command    (command),
    .address    (address),
    .nibble_in  (nibble_in),
    .nibble_out (nibble_out),
    .selected   (selected),
    .configured (configured),
`ifdef HP48_BUS_RAM_DAISY_EN
    .daisy_in   (daisy_in),
    .daisy_out  (daisy_out),
`endif
    .bus_error  (bus_error)
  );

  // Reference model state.
  logic [3:0]  m_ram [4096];
  logic [19:0] m_pc, m_dp, m_mask, m_base;
  int          m_state;  // 0 unconfigured, 1 sized, 2 configured
  logic [3:0]  m_nout;
  logic        m_sel, m_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [19:0] a);
    return (m_state == 2) && ((a & m_mask) == m_base);
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic step(input bit rst_n, input bit stb, input logic [3:0] cmd,
                      input logic [19:0] addr, input logic [3:0] nib);
    bit cfg_ok;
    reset     = rst_n;
    strobe    = stb;
    command   = cmd;
    address   = addr;
    nibble_in = nib;
    @(posedge clk);
    #1;
`ifdef HP48_BUS_RAM_DAISY_EN
    cfg_ok = daisy_in;
`else
    cfg_ok = 1'b1;
`endif
    if (!rst_n) begin
      m_pc = 0; m_dp = 0; m_mask = 0; m_base = 0; m_state = 0;
      m_nout = 0; m_sel = 0; m_err = 0;
    end else begin
      m_sel = 1'b0;
      if (stb) begin
        case (cmd)
          4'h0: ;
          4'h1: begin
            if (m_hit(m_pc)) begin m_nout = m_ram[m_pc[11:0]]; m_sel = 1'b1; end
            else m_nout = 4'h0;
            m_pc = m_pc + 1;
          end
          4'h2: begin
            if (m_hit(m_dp)) begin m_nout = m_ram[m_dp[11:0]]; m_sel = 1'b1; end
            else m_nout = 4'h0;
            m_dp = m_dp + 1;
          end
          4'h3: begin
            if (m_hit(m_dp)) m_ram[m_dp[11:0]] = nib;
            m_dp = m_dp + 1;
          end
          4'h4: m_pc = addr;
          4'h5: m_dp = addr;
          4'h6: begin
            if (cfg_ok) begin
              if (m_state == 0) begin m_mask = addr; m_state = 1; end
              else if (m_state == 1) begin m_base = addr & m_mask; m_state = 2; end
            end
          end
          4'h7: begin m_state = 0; m_mask = 0; m_base = 0; m_err = 0; end
          default: m_err = 1'b1;
        endcase
      end
    end
    strobe = 1'b0;
    check_eq("nibble_out", {28'd0, nibble_out}, {28'd0, m_nout});
    check_eq("selected", {31'd0, selected}, {31'd0, m_sel});
    check_eq("configured", {31'd0, configured}, (m_state == 2) ? 32'd1 : 32'd0);
    check_eq("bus_error", {31'd0, bus_error}, {31'd0, m_err});
`ifdef HP48_BUS_RAM_DAISY_EN
    check_eq("daisy_out", {31'd0, daisy_out}, (m_state == 2) ? 32'd1 : 32'd0);
`endif
  endtask

  task automatic cmd(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n);
    step(1'b1, 1'b1, c, a, n);
  endtask

  initial begin
    logic [19:0] hi_tbl [4];
    logic [19:0] mask_tbl [4];
    logic [19:0] a;
    int          r;
    logic [3:0]  c;

    hi_tbl[0] = 20'h00000; hi_tbl[1] = 20'h80000; hi_tbl[2] = 20'h90000; hi_tbl[3] = 20'hF0000;
    mask_tbl[0] = 20'hF0000; mask_tbl[1] = 20'hFF000; mask_tbl[2] = 20'hE0000;
    mask_tbl[3] = 20'h00000;
    for (int i = 0; i < 4096; i++) m_ram[i] = 4'h0;
    daisy_in = 1'b1;

    // Reset state, NOP, and a read while unconfigured.
    step(1'b0, 1'b0, 4'h0, 20'h0, 4'h0);
    step(1'b0, 1'b1, 4'h1, 20'h0, 4'h0);
    cmd(4'h0, 20'h0, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("unconf_read_sel", {31'd0, selected}, 32'd0);

    // Claim everything and fill the RAM so all later reads are defined.
    cmd(4'h6, 20'h00000, 4'h0);
    cmd(4'h6, 20'h00000, 4'h0);
    cmd(4'h5, 20'h00000, 4'h0);
    for (int i = 0; i < 4096; i++) cmd(4'h3, 20'h0, 4'($urandom));
    cmd(4'h7, 20'h0, 4'h0);

    // Window at 8xxxx: write A,5 then read them back.
    cmd(4'h6, 20'hF0000, 4'h0);
    check_eq("sized_not_conf", {31'd0, configured}, 32'd0);
    cmd(4'h6, 20'h80000, 4'h0);
    check_eq("conf_after_two", {31'd0, configured}, 32'd1);
    cmd(4'h5, 20'h80010, 4'h0);
    cmd(4'h3, 20'h0, 4'hA);
    cmd(4'h3, 20'h0, 4'h5);
    cmd(4'h4, 20'h80010, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("read_a", {28'd0, nibble_out}, 32'hA);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("read_5", {28'd0, nibble_out}, 32'h5);
    check_eq("read_5_sel", {31'd0, selected}, 32'd1);
    cmd(4'h0, 20'h0, 4'h0);
    check_eq("sel_drops", {31'd0, selected}, 32'd0);

    // Out-of-window write is dropped; in-window read returns old content.
    cmd(4'h5, 20'h90000, 4'h0);
    cmd(4'h3, 20'h0, 4'h7);
    cmd(4'h4, 20'h90000, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);
    cmd(4'h4, 20'h80000, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);

    // Pointer wrap with window at 00000.
    cmd(4'h7, 20'h0, 4'h0);
    cmd(4'h6, 20'hF0000, 4'h0);
    cmd(4'h6, 20'h00000, 4'h0);
    cmd(4'h4, 20'hFFFFF, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("wrap_miss_sel", {31'd0, selected}, 32'd0);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("wrap_hit_sel", {31'd0, selected}, 32'd1);

    // Illegal command sticks until the RESET command.
    cmd(4'h9, 20'h0, 4'h0);
    check_eq("err_set", {31'd0, bus_error}, 32'd1);
    cmd(4'h0, 20'h0, 4'h0);
    check_eq("err_held", {31'd0, bus_error}, 32'd1);
    cmd(4'h7, 20'h0, 4'h0);
    check_eq("err_clr", {31'd0, bus_error}, 32'd0);
    cmd(4'h6, 20'hF0000, 4'h0);
    cmd(4'h6, 20'h80000, 4'h0);
    cmd(4'h4, 20'h80010, 4'h0);
    cmd(4'h1, 20'h0, 4'h0);
    check_eq("ram_kept", {28'd0, nibble_out}, 32'hA);

    // Reset between the two CONFIGUREs returns to unconfigured.
    cmd(4'h7, 20'h0, 4'h0);
    cmd(4'h6, 20'hF0000, 4'h0);
    step(1'b0, 1'b1, 4'h6, 20'h80000, 4'h0);
    cmd(4'h6, 20'hF0000, 4'h0);
    check_eq("reset_mid_cfg", {31'd0, configured}, 32'd0);
    cmd(4'h7, 20'h0, 4'h0);

`ifdef HP48_BUS_RAM_DAISY_EN
    daisy_in = 1'b0;
    cmd(4'h6, 20'hF0000, 4'h0);
    cmd(4'h6, 20'h80000, 4'h0);
    check_eq("daisy_block", {31'd0, daisy_out}, 32'd0);
    daisy_in = 1'b1;
    cmd(4'h6, 20'hF0000, 4'h0);
    cmd(4'h6, 20'h80000, 4'h0);
    check_eq("daisy_pass", {31'd0, daisy_out}, 32'd1);
    cmd(4'h7, 20'h0, 4'h0);
`endif

    // Randomized command stream against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = hi_tbl[$urandom_range(0, 3)] | 20'($urandom_range(0, 65535));
`ifdef HP48_BUS_RAM_DAISY_EN
      daisy_in = ($urandom_range(0, 9) != 0);
`endif
      if (r < 1) begin
        step(1'b0, 1'($urandom), 4'($urandom), a, 4'($urandom));
      end else if (r < 10) begin
        step(1'b1, 1'b0, 4'($urandom), a, 4'($urandom));
      end else begin
        if (m_state != 2 && $urandom_range(0, 1) == 0) begin
          c = 4'h6;
          if (m_state == 0) a = mask_tbl[$urandom_range(0, 3)];
        end else if (r < 12) c = 4'($urandom_range(8, 15));
        else if (r < 13) c = 4'h7;
        else c = 4'($urandom_range(0, 6));
        cmd(c, a, 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
